// File: rtl/sparsity_scan_ctrl_if.sv
// Bus bundle between the sparsity scan sequencer, the flag RAM and the PE-side consumer.
// The abort input exists only when SPARSITY_SCAN_CTRL_ABORT_EN is defined.
interface sparsity_scan_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 4,
    parameter int unsigned ACT_LEN    = 16
);
    logic                          mode;
    logic                          start;
    logic [ADDR_WIDTH-1:0]         base_addr;
    logic                          busy;
    logic                          flag_rd_req;
    logic [ADDR_WIDTH-1:0]         flag_rd_addr;
    logic                          flag_rd_data;
    logic [ACT_LEN*IDX_WIDTH-1:0]  idx_array;
    logic [4:0]                    valid_cnt;
    logic [5:0]                    row_cnt;
    logic                          out_valid;
    logic                          out_ready;
`ifdef SPARSITY_SCAN_CTRL_ABORT_EN
    logic                          abort;

    modport master (
        input  mode, start, base_addr, flag_rd_data, out_ready, abort,
        output busy, flag_rd_req, flag_rd_addr, idx_array, valid_cnt, row_cnt, out_valid
    );
    modport slave (
        output mode, start, base_addr, flag_rd_data, out_ready, abort,
        input  busy, flag_rd_req, flag_rd_addr, idx_array, valid_cnt, row_cnt, out_valid
    );
`else
    modport master (
        input  mode, start, base_addr, flag_rd_data, out_ready,
        output busy, flag_rd_req, flag_rd_addr, idx_array, valid_cnt, row_cnt, out_valid
    );
    modport slave (
        output mode, start, base_addr, flag_rd_data, out_ready,
        input  busy, flag_rd_req, flag_rd_addr, idx_array, valid_cnt, row_cnt, out_valid
    );
`endif
endinterface

// File: rtl/sparsity_scan_ctrl.sv
// Burst-reads the 1-bit sparsity flag RAM, compacts nonzero positions and hands the result over
// a valid/ready handshake. Optional abort input enabled by SPARSITY_SCAN_CTRL_ABORT_EN.
module sparsity_scan_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 4,
    parameter int unsigned ACT_LEN    = 16,
    parameter int unsigned WEI_LEN    = 9
) (
    input  logic                clk,
    input  logic                reset,
    sparsity_scan_ctrl_if.master bus
);
    localparam int unsigned CntW  = $clog2(ACT_LEN + 1);
    localparam int unsigned SlotW = $clog2(ACT_LEN);
    localparam int unsigned ArrW  = ACT_LEN * IDX_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  wei_q, wei_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CntW-1:0]       k_q, k_d;
    logic [CntW-1:0]       p_q, p_d;
    logic                  cap_q, cap_d;
    logic [ArrW-1:0]       idx_q, idx_d;
    logic [4:0]            vcnt_q, vcnt_d;
    logic [5:0]            row_q, row_d;
    logic [CntW-1:0]       last_k;
    logic [SlotW-1:0]      slot;

    assign last_k = wei_q ? CntW'(WEI_LEN - 1) : CntW'(ACT_LEN - 1);
    assign slot   = SlotW'(vcnt_q);

    always_comb begin
        state_d = state_q;
        wei_d   = wei_q;
        base_d  = base_q;
        k_d     = k_q;
        p_d     = p_q;
        idx_d   = idx_q;
        vcnt_d  = vcnt_q;
        row_d   = row_q;
        cap_d   = (state_q == READ);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    wei_d   = bus.mode;
                    base_d  = bus.base_addr;
                    k_d     = '0;
                    p_d     = '0;
                    idx_d   = '0;
                    vcnt_d  = '0;
                    row_d   = '0;
                end
            end
            READ: begin
                k_d = k_q + CntW'(1);
                if (k_q == last_k) state_d = DRAIN;
            end
            DRAIN: state_d = DONE;
            default: begin
                if (bus.out_ready) state_d = IDLE;
            end
        endcase

        // Flag data trails its request by one cycle, so capture runs on the delayed strobe.
        if (cap_q) begin
            p_d = p_q + CntW'(1);
            if (bus.flag_rd_data) begin
                idx_d[slot*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(p_q);
                vcnt_d = vcnt_q + 5'd1;
                if (wei_q) begin
                    if (p_q < CntW'(3))      row_d[1:0] = row_q[1:0] + 2'd1;
                    else if (p_q < CntW'(6)) row_d[3:2] = row_q[3:2] + 2'd1;
                    else                     row_d[5:4] = row_q[5:4] + 2'd1;
                end
            end
        end

`ifdef SPARSITY_SCAN_CTRL_ABORT_EN
        if (bus.abort && (state_q == READ || state_q == DRAIN)) begin
            state_d = IDLE;
            cap_d   = 1'b0;
            k_d     = '0;
            p_d     = '0;
            idx_d   = '0;
            vcnt_d  = '0;
            row_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wei_q   <= 1'b0;
            base_q  <= '0;
            k_q     <= '0;
            p_q     <= '0;
            cap_q   <= 1'b0;
            idx_q   <= '0;
            vcnt_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            wei_q   <= wei_d;
            base_q  <= base_d;
            k_q     <= k_d;
            p_q     <= p_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            vcnt_q  <= vcnt_d;
            row_q   <= row_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.flag_rd_req  = (state_q == READ);
    assign bus.flag_rd_addr = (state_q == READ) ? base_q + ADDR_WIDTH'(k_q) : '0;
    assign bus.idx_array    = idx_q;
    assign bus.valid_cnt    = vcnt_q;
    assign bus.row_cnt      = row_q;
    assign bus.out_valid    = (state_q == DONE);
endmodule

// File: tb/tb_sparsity_scan_ctrl.sv
// Directed bench for sparsity_scan_ctrl: flag RAM model plus a scoreboard of expected results.
// Abort scenario is exercised when SPARSITY_SCAN_CTRL_ABORT_EN is defined.
module tb_sparsity_scan_ctrl;
    localparam int AW = 8;
    localparam int IW = 4;
    localparam int AL = 16;
    localparam int WL = 9;

    typedef struct packed {
        logic [AL*IW-1:0] idx;
        logic [4:0]       cnt;
        logic [5:0]       row;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sparsity_scan_ctrl_if #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW), .ACT_LEN(AL)) bus ();

    sparsity_scan_ctrl #(
        .ADDR_WIDTH(AW),
        .IDX_WIDTH (IW),
        .ACT_LEN   (AL),
        .WEI_LEN   (WL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    logic flag_mem [256];
    always @(posedge clk) bus.flag_rd_data <= bus.flag_rd_req ? flag_mem[bus.flag_rd_addr] : 1'b0;

    res_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input bit wmode, input logic [AW-1:0] base);
        res_t r;
        int   len;
        logic [AW-1:0] a;
        r   = '0;
        len = wmode ? WL : AL;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            if (flag_mem[a]) begin
                r.idx[int'(r.cnt)*IW +: IW] = IW'(i);
                r.cnt = r.cnt + 5'd1;
                if (wmode) r.row[(i/3)*2 +: 2] = r.row[(i/3)*2 +: 2] + 2'd1;
            end
        end
        return r;
    endfunction

    task automatic set_flags(input logic [AW-1:0] base, input int len, input logic [15:0] pat);
        logic [AW-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            flag_mem[a] = pat[i];
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 0);
        chk({tag, "_req"}, 64'(bus.flag_rd_req), 0);
        chk({tag, "_valid"}, 64'(bus.out_valid), 0);
        chk({tag, "_cnt"}, 64'(bus.valid_cnt), 0);
        chk({tag, "_row"}, 64'(bus.row_cnt), 0);
        chk({tag, "_idx"}, bus.idx_array, 0);
    endtask

    // cut_at > 0 interrupts the burst in that request cycle (reset, or abort when use_abort).
    task automatic do_scan(input bit wmode, input logic [AW-1:0] base, input bit rdy,
                           input int hold, input int cut_at, input bit use_abort,
                           input bit poke, output res_t got);
        res_t          exp_r;
        int            n;
        int            len;
        bit            seen;
        logic [AW-1:0] ea;
        len = wmode ? WL : AL;
        got = '0;
        @(negedge clk);
        bus.mode      = wmode;
        bus.base_addr = base;
        bus.start     = 1'b1;
        bus.out_ready = rdy;
        sb.push_back(model(wmode, base));
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.start     = 1'b0;
                bus.mode      = ~wmode;
                bus.base_addr = ~base;
                chk("busy_rise", 64'(bus.busy), 1);
            end
            if (cut_at > 0 && n == cut_at + 1) begin
                reset = 1'b0;
`ifdef SPARSITY_SCAN_CTRL_ABORT_EN
                bus.abort = 1'b0;
`endif
                check_idle_zero(use_abort ? "abort" : "midrst");
                void'(sb.pop_back());
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("cut_no_valid", 64'(bus.out_valid), 0);
                    chk("cut_no_req", 64'(bus.flag_rd_req), 0);
                end
                return;
            end
            if (n <= len) begin
                ea = base + AW'(n - 1);
                chk("rd_req", 64'(bus.flag_rd_req), 1);
                chk("rd_addr", 64'(bus.flag_rd_addr), 64'(ea));
            end else if (!bus.out_valid) begin
                chk("drain_req", 64'(bus.flag_rd_req), 0);
            end
            if (n == cut_at) begin
                if (use_abort) begin
`ifdef SPARSITY_SCAN_CTRL_ABORT_EN
                    bus.abort = 1'b1;
`endif
                end else begin
                    reset = 1'b1;
                end
            end
            seen = bus.out_valid;
        end
        chk("latency", 64'(n), 64'(len + 2));
        exp_r = sb.pop_front();
        got.idx = bus.idx_array;
        got.cnt = bus.valid_cnt;
        got.row = bus.row_cnt;
        chk("sb_idx", got.idx, exp_r.idx);
        chk("sb_cnt", 64'(got.cnt), 64'(exp_r.cnt));
        chk("sb_row", 64'(got.row), 64'(exp_r.row));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 1);
            chk("hold_busy", 64'(bus.busy), 1);
            chk("hold_idx", bus.idx_array, exp_r.idx);
            chk("hold_cnt", 64'(bus.valid_cnt), 64'(exp_r.cnt));
            bus.start = poke && (h == 1);
        end
        bus.out_ready = 1'b1;
        bus.start     = poke;
        @(negedge clk);
        bus.start = 1'b0;
        chk("hs_valid", 64'(bus.out_valid), 0);
        chk("hs_busy", 64'(bus.busy), 0);
        @(negedge clk);
        chk("post_busy", 64'(bus.busy), 0);
        chk("post_req", 64'(bus.flag_rd_req), 0);
        bus.out_ready = 1'b0;
    endtask

    res_t r;

    initial begin
        for (int i = 0; i < 256; i++) flag_mem[i] = 1'b0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.base_addr = '0;
        bus.out_ready = 1'b0;
`ifdef SPARSITY_SCAN_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        @(negedge clk);
        check_idle_zero("reset");
        chk("reset_addr", 64'(bus.flag_rd_addr), 0);
        bus.start = 1'b0;
        reset     = 1'b0;

        // Weight kernel with rows {1,0,1},{0,0,0},{1,1,1}.
        set_flags(8'h10, WL, 16'b111_000_101);
        do_scan(1'b1, 8'h10, 1'b1, 0, 0, 1'b0, 1'b1, r);
        chk("w_cnt", 64'(r.cnt), 5);
        chk("w_idx", r.idx, 64'h0000_0000_0008_7620);
        chk("w_row", 64'(r.row), 64'(6'b11_00_10));

        // Activation line wrapping past 0xFF, flags at positions 3 and 15, with backpressure.
        set_flags(8'hF8, AL, 16'h8008);
        do_scan(1'b0, 8'hF8, 1'b0, 5, 0, 1'b0, 1'b1, r);
        chk("a_cnt", 64'(r.cnt), 2);
        chk("a_idx", r.idx, 64'hF3);
        chk("a_row", 64'(r.row), 0);

        set_flags(8'h40, AL, 16'h0000);
        do_scan(1'b0, 8'h40, 1'b1, 0, 0, 1'b0, 1'b0, r);
        chk("zero_cnt", 64'(r.cnt), 0);
        chk("zero_idx", r.idx, 0);

        set_flags(8'h80, AL, 16'hFFFF);
        do_scan(1'b0, 8'h80, 1'b1, 0, 0, 1'b0, 1'b0, r);
        chk("ones_cnt", 64'(r.cnt), 16);
        chk("ones_idx", r.idx, 64'hFEDC_BA98_7654_3210);
        chk("ones_row", 64'(r.row), 0);

        do_scan(1'b1, 8'h80, 1'b1, 0, 0, 1'b0, 1'b0, r);
        chk("wones_cnt", 64'(r.cnt), 9);
        chk("wones_row", 64'(r.row), 64'h3F);

        // Reset in the 4th request cycle, then a clean rerun.
        do_scan(1'b1, 8'h10, 1'b1, 0, 4, 1'b0, 1'b0, r);
        do_scan(1'b1, 8'h10, 1'b0, 2, 0, 1'b0, 1'b0, r);
        chk("rerun_cnt", 64'(r.cnt), 5);
        chk("rerun_row", 64'(r.row), 64'(6'b11_00_10));

`ifdef SPARSITY_SCAN_CTRL_ABORT_EN
        do_scan(1'b0, 8'h80, 1'b1, 0, 6, 1'b1, 1'b0, r);
        do_scan(1'b0, 8'h80, 1'b1, 0, 0, 1'b0, 1'b0, r);
        chk("post_abort_cnt", 64'(r.cnt), 16);
`endif

        chk("sb_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
